load_store_unit: RTL
====================

# load_store_unit

Clocked initiator for the data port of the integrated instruction/data memory. Accepts byte/halfword/word load and store requests from the datapath, drives the memory's word-wide, byte-addressable, little-endian data port (address, write data, read strobe, write strobe), and returns a single-cycle response. Sub-word stores are done as read-modify-write because the memory only writes whole words.

## Interface
- `DATA_LIMIT`, 32'h0000_1000: first address outside the data region; any request with `req_addr >= DATA_LIMIT` is rejected.
- `WRITE_HOLD`, 1: cycles (≥1) `mem_write` stays low with address/data held after the strobe cycle.
- Clock and reset: one clock; reset is asynchronous and active-low.
- `clk` in 1: clock, all state updates on its rising edge.
- `rst_n` in 1: asynchronous active-low reset.
- `req_valid` in 1: request present.
- `req_ready` out 1: high only in IDLE; request accepted on an edge where `req_valid && req_ready`.
- `req_we` in 1: 1 = store, 0 = load.
- `req_size` in 2: 00 byte, 01 halfword, 10 word, 11 reserved (treated as an error).
- `req_unsigned` in 1: load zero-extends when 1, sign-extends when 0.
- `req_addr` in 32: byte address.
- `req_wdata` in 32: store data, right-justified.
- `resp_valid` out 1: one-cycle completion pulse; no backpressure.
- `resp_err` out 1: valid with `resp_valid`; 1 = rejected, no memory access made.
- `resp_rdata` out 32: extended load data; 0 for stores and errors.
- `mem_addr` out 32: word-aligned address (`req_addr & ~3`).
- `mem_wdata` out 32: full word to write.
- `mem_read` out 1: read strobe.
- `mem_write` out 1: write strobe; memory captures on its rising edge.
- `mem_rdata` in 32: read data, valid before the next edge while `mem_read` is high.

## Operation
- States: IDLE, RD, WR, HOLD, RESP.
- IDLE: on accept, register the request fields.
  - Error → RESP with `resp_err`=1.
  - Load or sub-word store → RD.
  - Word store → WR with `mem_wdata = req_wdata`.
- RD: `mem_read`=1. At the next edge capture `mem_rdata`.
  - Load → RESP with the extracted data.
  - Store → WR with the merged word.
- WR: `mem_write`=1 for exactly one cycle → HOLD.
- HOLD: `mem_write`=0, `mem_addr`/`mem_wdata` unchanged for `WRITE_HOLD` cycles → RESP.
- RESP: `resp_valid`=1 for one cycle → IDLE.
- Lanes: byte at offset k occupies bits [8k+7:8k]; halfword at offset 0 uses [15:0], at offset 2 uses [31:16].
- Load extract: shift the word right by 8·addr[1:0], then sign- or zero-extend from bit 7 or bit 15.
- Store merge: replace only the addressed lanes; other lanes keep the value read.
- Reserved `req_size` and out-of-range address are always errors.

## Timing
- Reset values: `req_ready`=1, all other outputs 0, state IDLE. `mem_addr`, `mem_wdata` and `resp_rdata` are registered.
- Latency from the accept edge to the `resp_valid` cycle:
  - Load: 2 cycles.
  - Word store: 2+`WRITE_HOLD` cycles.
  - Sub-word store: 3+`WRITE_HOLD` cycles.
  - Error: 1 cycle.
- `mem_read` and `mem_write` are never high in the same cycle.
- Minimum clock period is 10 time units, covering the memory's 1-unit read delay and its 4-unit staggered byte writes.
- `req_ready` is low from accept through RESP, so back-to-back requests are spaced by at least one IDLE cycle.
- Reset mid-operation: `mem_write`/`mem_read` drop at once, no `resp_valid` is issued, and memory contents are undefined for a partially strobed word.
- `req_valid` in a non-IDLE state is ignored.

## Configuration
- Macro: `LSU_ALIGN_CHECK_EN`.
- Defined: a halfword with addr[0]=1, or a word with addr[1:0]≠0, is an error (`resp_err`=1, no strobe).
- Undefined: misaligned addresses are aligned down silently (halfword clears bit 0, word clears bits 1:0) and the access proceeds.

## Structure
- `lsu_pkg`:
  - size encodings `SZ_BYTE`, `SZ_HALF`, `SZ_WORD`;
  - state enum;
  - default `DATA_LIMIT` constant.
- One combinational sub-module, `data_lane_align`: from offset, size and unsigned flag, produces both the extracted load value and the merged store word.

## Test plan
- Memory word at 0x0010 = 32'h8070_FF01; lb 0x0013 → `resp_rdata` 32'hFFFF_FF80. lbu 0x0012 → 32'h0000_0070. Response 2 cycles after accept.
- Same word; lh 0x0012 → 32'hFFFF_8070. lhu 0x0010 → 32'h0000_FF01.
- sb 0x0011 with data 32'h0000_00AB → one `mem_read` pulse, then one `mem_write` pulse with `mem_wdata` 32'h8070_AB01; word reads back 32'h8070_AB01. Response at 3+`WRITE_HOLD` cycles.
- sw 0x0020 with data 32'hDEAD_BEEF → no `mem_read`; one `mem_write` pulse; address held through HOLD; lw 0x0020 returns 32'hDEAD_BEEF.
- lw 0x1000 (`DATA_LIMIT`), and lh 0x0011 with `LSU_ALIGN_CHECK_EN` defined → `resp_err`=1 after 1 cycle, no strobes. Without the macro, lh 0x0011 reads offset 0 (32'hFFFF_FF01 for the word above).
- Assert `rst_n`=0 during the WR cycle of a store → `mem_write` falls immediately, no `resp_valid`, `req_ready`=1 after release.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: access-size encodings,
// controller state enum and the default top of the data region.
package lsu_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_RSVD = 2'b11;

  // First byte address outside the data region.
  localparam logic [31:0] DEFAULT_DATA_LIMIT = 32'h0000_1000;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD,
    ST_WR,
    ST_HOLD,
    ST_RESP
  } lsu_state_t;

endpackage

// File: rtl/data_lane_align.sv
// Little-endian lane steering between a memory word and the datapath.
// Produces the sign/zero-extended load value and the read-modify-write
// store word for the addressed byte/halfword lanes. Purely combinational.
module data_lane_align
  import lsu_pkg::*;
(
  input  logic [1:0]  offset,
  input  logic [1:0]  size,
  input  logic        is_unsigned,
  input  logic [31:0] word,
  input  logic [31:0] wdata,
  output logic [31:0] load_data,
  output logic [31:0] store_word
);

  logic [4:0]  shamt;
  logic [31:0] shifted;
  logic [31:0] lane_mask;
  logic [31:0] lane_data;

  assign shamt     = {offset, 3'b000};
  assign shifted   = word >> shamt;
  assign lane_data = wdata << shamt;

  // Select the extension width for loads and the lane mask for stores.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first so
    // no path through the case leaves it unassigned (which would infer a latch).
    load_data = shifted;
    lane_mask = 32'hFFFF_FFFF;
    unique case (size)
      SZ_BYTE: begin
        load_data = {{24{~is_unsigned & shifted[7]}}, shifted[7:0]};
        lane_mask = 32'h0000_00FF << shamt;
      end
      SZ_HALF: begin
        load_data = {{16{~is_unsigned & shifted[15]}}, shifted[15:0]};
        lane_mask = 32'h0000_FFFF << shamt;
      end
      default: begin
        load_data = shifted;
        lane_mask = 32'hFFFF_FFFF;
      end
    endcase
  end

  // Replace only the addressed lanes; untouched lanes keep the word read.
  assign store_word = (word & ~lane_mask) | (lane_data & lane_mask);

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: single-outstanding initiator for the word-wide,
// byte-addressable data port. Sub-word stores are read-modify-write.
// Optional feature: define LSU_ALIGN_CHECK_EN to reject misaligned
// halfword/word requests; otherwise they are aligned down silently.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter logic [31:0] DATA_LIMIT = DEFAULT_DATA_LIMIT,
  parameter int unsigned WRITE_HOLD = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic        resp_err,
  output logic [31:0] resp_rdata,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        mem_read,
  output logic        mem_write,
  input  logic [31:0] mem_rdata
);

  localparam int HCW = (WRITE_HOLD > 1) ? $clog2(WRITE_HOLD) : 1;

  lsu_state_t     state, state_nxt;
  logic           r_we;
  logic [1:0]     r_size;
  logic           r_uns;
  logic [1:0]     r_off;
  logic [31:0]    r_wdata;
  logic [HCW-1:0] hold_cnt;

  logic           accept;
  logic           misaligned;
  logic           req_err;
  logic           word_store;
  logic [1:0]     eff_off;
  logic [31:0]    load_data;
  logic [31:0]    store_word;

  assign accept     = req_valid && req_ready;
  assign word_store = req_we && (req_size == SZ_WORD);

`ifdef LSU_ALIGN_CHECK_EN
  assign misaligned = ((req_size == SZ_HALF) && req_addr[0]) ||
                      ((req_size == SZ_WORD) && (req_addr[1:0] != 2'b00));
`else
  assign misaligned = 1'b0;
`endif

  assign req_err = (req_size == SZ_RSVD) || (req_addr >= DATA_LIMIT) || misaligned;

  // Lane offset after silent alignment: halfword drops bit 0, word drops both.
  assign eff_off = (req_size == SZ_WORD) ? 2'b00 :
                   (req_size == SZ_HALF) ? {req_addr[1], 1'b0} : req_addr[1:0];

  data_lane_align u_align (
    .offset      (r_off),
    .size        (r_size),
    .is_unsigned (r_uns),
    .word        (mem_rdata),
    .wdata       (r_wdata),
    .load_data   (load_data),
    .store_word  (store_word)
  );

  // State register; reset returns to IDLE at once, dropping any strobe.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of block evaluation order.
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  // Next-state decode.
  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_IDLE: begin
        if (accept) begin
          if (req_err)         state_nxt = ST_RESP;
          else if (word_store) state_nxt = ST_WR;
          else                 state_nxt = ST_RD;
        end
      end
      ST_RD:   state_nxt = r_we ? ST_WR : ST_RESP;
      ST_WR:   state_nxt = ST_HOLD;
      ST_HOLD: if (hold_cnt == '0) state_nxt = ST_RESP;
      ST_RESP: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Strobes and handshakes are pure functions of the state, so read and
  // write can never overlap.
  always_comb begin
    req_ready  = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    resp_valid = 1'b0;
    unique case (state)
      ST_IDLE: req_ready  = 1'b1;
      ST_RD:   mem_read   = 1'b1;
      ST_WR:   mem_write  = 1'b1;
      ST_HOLD: ;
      ST_RESP: resp_valid = 1'b1;
      default: ;
    endcase
  end

  // Request capture, memory address/data registers and response data.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: the datapath registers drive outputs directly, so they are all
    // reset to give defined port values out of reset.
    if (!rst_n) begin
      r_we       <= 1'b0;
      r_size     <= SZ_BYTE;
      r_uns      <= 1'b0;
      r_off      <= 2'b00;
      r_wdata    <= '0;
      hold_cnt   <= '0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      resp_err   <= 1'b0;
      resp_rdata <= '0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (accept) begin
            r_we       <= req_we;
            r_size     <= req_size;
            r_uns      <= req_unsigned;
            r_off      <= eff_off;
            r_wdata    <= req_wdata;
            resp_err   <= req_err;
            resp_rdata <= '0;
            if (!req_err) begin
              mem_addr <= {req_addr[31:2], 2'b00};
              if (word_store) mem_wdata <= req_wdata;
            end
          end
        end
        ST_RD: begin
          if (r_we) mem_wdata  <= store_word;
          else      resp_rdata <= load_data;
        end
        ST_WR:   hold_cnt <= HCW'(WRITE_HOLD - 1);
        ST_HOLD: hold_cnt <= hold_cnt - 1'b1;
        ST_RESP: begin
          resp_err   <= 1'b0;
          resp_rdata <= '0;
        end
        default: ;
      endcase
    end
  end

endmodule
